// File: rtl/way_data_writer_if.sv
// Bundles the fill-request, refill-beat, store and array-write signals of the cache way data writer.
// The master modport is the request/memory side; the slave modport is the writer itself.
interface way_data_writer_if #(
  parameter int unsigned NUM_WAYS     = 4,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned OFFSET_WIDTH = 3,
  parameter int unsigned INDEX_WIDTH  = 6
);
  logic                    fill_req_valid;
  logic                    fill_req_ready;
  logic [NUM_WAYS-1:0]     fill_way;
  logic [INDEX_WIDTH-1:0]  fill_index;
  logic [OFFSET_WIDTH-1:0] fill_offset;

  logic                    mem_valid;
  logic                    mem_ready;
  logic [DATA_WIDTH-1:0]   mem_data;

  logic                    st_valid;
  logic                    st_ready;
  logic [NUM_WAYS-1:0]     st_way;
  logic [INDEX_WIDTH-1:0]  st_index;
  logic [OFFSET_WIDTH-1:0] st_offset;
  logic [DATA_WIDTH-1:0]   st_data;

  logic [NUM_WAYS-1:0]     wr_en;
  logic [INDEX_WIDTH-1:0]  wr_index;
  logic [OFFSET_WIDTH-1:0] wr_offset;
  logic [DATA_WIDTH-1:0]   wr_data;

  logic                    busy;
  logic                    fill_done;
  logic                    err_way;

  modport master (
    output fill_req_valid, fill_way, fill_index, fill_offset,
    output mem_valid, mem_data,
    output st_valid, st_way, st_index, st_offset, st_data,
    input  fill_req_ready, mem_ready, st_ready,
    input  wr_en, wr_index, wr_offset, wr_data,
    input  busy, fill_done, err_way
  );

  modport slave (
    input  fill_req_valid, fill_way, fill_index, fill_offset,
    input  mem_valid, mem_data,
    input  st_valid, st_way, st_index, st_offset, st_data,
    output fill_req_ready, mem_ready, st_ready,
    output wr_en, wr_index, wr_offset, wr_data,
    output busy, fill_done, err_way
  );
endinterface

// File: rtl/way_data_writer.sv
// Cache way data writer: serialises line-fill beats and single-word store hits into one-hot way array writes.
// Define WAY_WRITER_CRITICAL_WORD_FIRST_EN to start each fill at the requested critical word offset.
module way_data_writer #(
  parameter int unsigned NUM_WAYS     = 4,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned OFFSET_WIDTH = 3,
  parameter int unsigned INDEX_WIDTH  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  way_data_writer_if.slave  bus
);

  localparam int unsigned LINE_WORDS = 1 << OFFSET_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e                  state_q;
  logic                    fill_rdy_q;
  logic                    mem_rdy_q;
  logic                    busy_q;
  logic                    fill_done_q;
  logic                    err_way_q;
  logic [NUM_WAYS-1:0]     way_q;
  logic [INDEX_WIDTH-1:0]  index_q;
  logic [OFFSET_WIDTH-1:0] ptr_q;
  logic [OFFSET_WIDTH-1:0] cnt_q;
  logic [NUM_WAYS-1:0]     wr_en_q;
  logic [INDEX_WIDTH-1:0]  wr_index_q;
  logic [OFFSET_WIDTH-1:0] wr_offset_q;
  logic [DATA_WIDTH-1:0]   wr_data_q;

  logic st_ready_c;
  logic fill_acc_c;
  logic st_acc_c;
  logic beat_c;
  logic last_beat_c;
  logic fill_way_ok_c;
  logic st_way_ok_c;
  logic [OFFSET_WIDTH-1:0] start_ptr_c;

  // A pending fill request always wins over a store in the same cycle.
  assign st_ready_c    = fill_rdy_q & ~bus.fill_req_valid;
  assign fill_acc_c    = bus.fill_req_valid & fill_rdy_q;
  assign st_acc_c      = bus.st_valid & st_ready_c;
  assign beat_c        = bus.mem_valid & mem_rdy_q;
  assign last_beat_c   = (cnt_q == OFFSET_WIDTH'(LINE_WORDS - 1));
  assign fill_way_ok_c = $onehot(bus.fill_way);
  assign st_way_ok_c   = $onehot(bus.st_way);

`ifdef WAY_WRITER_CRITICAL_WORD_FIRST_EN
  assign start_ptr_c = bus.fill_offset;
`else
  assign start_ptr_c = '0;
`endif

  // Fill FSM and all registered outputs; write strobes and pulses default low every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      fill_rdy_q  <= 1'b1;
      mem_rdy_q   <= 1'b0;
      busy_q      <= 1'b0;
      fill_done_q <= 1'b0;
      err_way_q   <= 1'b0;
      way_q       <= '0;
      index_q     <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
      wr_en_q     <= '0;
      wr_index_q  <= '0;
      wr_offset_q <= '0;
      wr_data_q   <= '0;
    end else begin
      wr_en_q     <= '0;
      fill_done_q <= 1'b0;
      err_way_q   <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (fill_acc_c) begin
            if (fill_way_ok_c) begin
              state_q    <= S_FILL;
              fill_rdy_q <= 1'b0;
              mem_rdy_q  <= 1'b1;
              busy_q     <= 1'b1;
              way_q      <= bus.fill_way;
              index_q    <= bus.fill_index;
              ptr_q      <= start_ptr_c;
              cnt_q      <= '0;
            end else begin
              err_way_q <= 1'b1;
            end
          end else if (st_acc_c) begin
            if (st_way_ok_c) begin
              wr_en_q     <= bus.st_way;
              wr_index_q  <= bus.st_index;
              wr_offset_q <= bus.st_offset;
              wr_data_q   <= bus.st_data;
            end else begin
              err_way_q <= 1'b1;
            end
          end
        end
        S_FILL: begin
          if (beat_c) begin
            wr_en_q     <= way_q;
            wr_index_q  <= index_q;
            wr_offset_q <= ptr_q;
            wr_data_q   <= bus.mem_data;
            ptr_q       <= OFFSET_WIDTH'(ptr_q + 1'b1);
            cnt_q       <= OFFSET_WIDTH'(cnt_q + 1'b1);
            if (last_beat_c) begin
              state_q     <= S_DONE;
              mem_rdy_q   <= 1'b0;
              fill_done_q <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state_q    <= S_IDLE;
          fill_rdy_q <= 1'b1;
          busy_q     <= 1'b0;
        end
        default: begin
          state_q    <= S_IDLE;
          fill_rdy_q <= 1'b1;
          mem_rdy_q  <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.fill_req_ready = fill_rdy_q;
  assign bus.mem_ready      = mem_rdy_q;
  assign bus.st_ready       = st_ready_c;
  assign bus.wr_en          = wr_en_q;
  assign bus.wr_index       = wr_index_q;
  assign bus.wr_offset      = wr_offset_q;
  assign bus.wr_data        = wr_data_q;
  assign bus.busy           = busy_q;
  assign bus.fill_done      = fill_done_q;
  assign bus.err_way        = err_way_q;

endmodule

// File: tb/tb_way_data_writer.sv
// Directed self-checking bench for way_data_writer: reset, fills, stalls, stores, arbitration, bad ways.
module tb_way_data_writer;
  localparam int unsigned NW = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned OW = 3;
  localparam int unsigned IW = 6;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  way_data_writer_if #(.NUM_WAYS(NW), .DATA_WIDTH(DW), .OFFSET_WIDTH(OW), .INDEX_WIDTH(IW)) bus ();

  way_data_writer #(.NUM_WAYS(NW), .DATA_WIDTH(DW), .OFFSET_WIDTH(OW), .INDEX_WIDTH(IW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.fill_req_valid = 1'b0; bus.fill_way = '0; bus.fill_index = '0; bus.fill_offset = '0;
    bus.mem_valid = 1'b0; bus.mem_data = '0;
    bus.st_valid = 1'b0; bus.st_way = '0; bus.st_index = '0; bus.st_offset = '0; bus.st_data = '0;
    #2;
    checks++; if (bus.wr_en !== 4'b0000) begin failures++; $display("FAIL rst_wr_en got %b exp 0000", bus.wr_en); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_busy got %b exp 0", bus.busy); end
    checks++; if (bus.mem_ready !== 1'b0) begin failures++; $display("FAIL rst_mem_ready got %b exp 0", bus.mem_ready); end
    checks++; if (bus.fill_done !== 1'b0 || bus.err_way !== 1'b0) begin failures++; $display("FAIL rst_pulses got %b%b exp 00", bus.fill_done, bus.err_way); end
    checks++; if (bus.wr_offset !== 3'd0 || bus.wr_data !== 32'h0 || bus.wr_index !== 6'd0) begin failures++; $display("FAIL rst_wr_bus got %h/%h/%h exp 0", bus.wr_index, bus.wr_offset, bus.wr_data); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++; if (bus.fill_req_ready !== 1'b1) begin failures++; $display("FAIL rst_fill_ready got %b exp 1", bus.fill_req_ready); end
    checks++; if (bus.st_ready !== 1'b1) begin failures++; $display("FAIL rst_st_ready got %b exp 1", bus.st_ready); end
  endtask

  // Clean fill, 8 back-to-back beats; fill_offset=6 matters only with critical-word-first.
  task automatic test_fill_basic();
    int unsigned base;
    logic [OW-1:0] eo;
`ifdef WAY_WRITER_CRITICAL_WORD_FIRST_EN
    base = 6;
`else
    base = 0;
`endif
    bus.fill_req_valid = 1'b1; bus.fill_way = 4'b0100; bus.fill_index = 6'd5; bus.fill_offset = 3'd6;
    #1;
    checks++; if (bus.fill_req_ready !== 1'b1) begin failures++; $display("FAIL fb_ready got %b exp 1", bus.fill_req_ready); end
    tick();
    bus.fill_req_valid = 1'b0;
    checks++; if (bus.busy !== 1'b1 || bus.mem_ready !== 1'b1) begin failures++; $display("FAIL fb_enter got busy=%b mem_ready=%b exp 1 1", bus.busy, bus.mem_ready); end
    checks++; if (bus.wr_en !== 4'b0000 || bus.fill_req_ready !== 1'b0) begin failures++; $display("FAIL fb_enter_idle got wr_en=%b ready=%b exp 0000 0", bus.wr_en, bus.fill_req_ready); end
    for (int i = 0; i < 8; i++) begin
      bus.mem_valid = 1'b1;
      bus.mem_data  = 32'hA0 + 32'(i);
      tick();
      eo = OW'(base + 32'(i));
      checks++; if (bus.wr_en !== 4'b0100 || bus.wr_index !== 6'd5) begin failures++; $display("FAIL fb_wr_way[%0d] got %b/%0d exp 0100/5", i, bus.wr_en, bus.wr_index); end
      checks++; if (bus.wr_offset !== eo || bus.wr_data !== 32'hA0 + 32'(i)) begin failures++; $display("FAIL fb_wr_word[%0d] got off=%0d data=%h exp off=%0d data=%h", i, bus.wr_offset, bus.wr_data, eo, 32'hA0 + 32'(i)); end
      checks++; if (bus.fill_done !== (i == 7) || bus.busy !== 1'b1) begin failures++; $display("FAIL fb_done[%0d] got done=%b busy=%b exp %b 1", i, bus.fill_done, bus.busy, (i == 7)); end
    end
    bus.mem_valid = 1'b0;
    tick();
    checks++; if (bus.busy !== 1'b0 || bus.wr_en !== 4'b0000 || bus.fill_done !== 1'b0) begin failures++; $display("FAIL fb_exit got busy=%b wr_en=%b done=%b exp 0 0000 0", bus.busy, bus.wr_en, bus.fill_done); end
    checks++; if (bus.fill_req_ready !== 1'b1 || bus.wr_data !== 32'hA7) begin failures++; $display("FAIL fb_exit_hold got ready=%b data=%h exp 1 a7", bus.fill_req_ready, bus.wr_data); end
  endtask

  // mem_valid toggles every other cycle; gaps must produce no write.
  task automatic test_fill_stall();
    int unsigned base;
    int k;
    logic mv;
    logic [OW-1:0] eo;
`ifdef WAY_WRITER_CRITICAL_WORD_FIRST_EN
    base = 3;
`else
    base = 0;
`endif
    bus.fill_req_valid = 1'b1; bus.fill_way = 4'b0010; bus.fill_index = 6'd9; bus.fill_offset = 3'd3;
    tick();
    bus.fill_req_valid = 1'b0;
    k = 0;
    for (int cyc = 0; cyc < 40 && k < 8; cyc++) begin
      mv = (cyc % 2 == 0);
      bus.mem_valid = mv;
      bus.mem_data  = 32'hC0 + 32'(k);
      tick();
      if (mv) begin
        eo = OW'(base + 32'(k));
        checks++; if (bus.wr_en !== 4'b0010 || bus.wr_offset !== eo || bus.wr_data !== 32'hC0 + 32'(k)) begin failures++; $display("FAIL st_beat[%0d] got %b/%0d/%h exp 0010/%0d/%h", k, bus.wr_en, bus.wr_offset, bus.wr_data, eo, 32'hC0 + 32'(k)); end
        checks++; if (bus.fill_done !== (k == 7)) begin failures++; $display("FAIL st_done[%0d] got %b exp %b", k, bus.fill_done, (k == 7)); end
        k++;
      end else begin
        checks++; if (bus.wr_en !== 4'b0000 || bus.mem_ready !== 1'b1) begin failures++; $display("FAIL st_gap[%0d] got wr_en=%b mem_ready=%b exp 0000 1", k, bus.wr_en, bus.mem_ready); end
      end
    end
    checks++; if (k != 8) begin failures++; $display("FAIL st_beats got %0d exp 8", k); end
    bus.mem_valid = 1'b1;
    tick();
    checks++; if (bus.wr_en !== 4'b0000 || bus.busy !== 1'b0) begin failures++; $display("FAIL st_after got wr_en=%b busy=%b exp 0000 0", bus.wr_en, bus.busy); end
    bus.mem_valid = 1'b0;
  endtask

  task automatic test_store();
    bus.st_valid = 1'b1; bus.st_way = 4'b0001; bus.st_index = 6'd3; bus.st_offset = 3'd2; bus.st_data = 32'hDEADBEEF;
    #1;
    checks++; if (bus.st_ready !== 1'b1) begin failures++; $display("FAIL sto_ready got %b exp 1", bus.st_ready); end
    tick();
    bus.st_valid = 1'b0;
    checks++; if (bus.wr_en !== 4'b0001 || bus.wr_index !== 6'd3 || bus.wr_offset !== 3'd2 || bus.wr_data !== 32'hDEADBEEF) begin failures++; $display("FAIL sto_write got %b/%0d/%0d/%h exp 0001/3/2/deadbeef", bus.wr_en, bus.wr_index, bus.wr_offset, bus.wr_data); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL sto_busy got %b exp 0", bus.busy); end
    tick();
    checks++; if (bus.wr_en !== 4'b0000) begin failures++; $display("FAIL sto_once got %b exp 0000", bus.wr_en); end
  endtask

  // Fill and store together: fill wins, store waits through the whole fill and is written afterwards.
  task automatic test_back_to_back();
    bus.fill_req_valid = 1'b1; bus.fill_way = 4'b1000; bus.fill_index = 6'd12; bus.fill_offset = 3'd0;
    bus.st_valid = 1'b1; bus.st_way = 4'b0001; bus.st_index = 6'd3; bus.st_offset = 3'd2; bus.st_data = 32'hDEADBEEF;
    #1;
    checks++; if (bus.st_ready !== 1'b0 || bus.fill_req_ready !== 1'b1) begin failures++; $display("FAIL arb_ready got st=%b fill=%b exp 0 1", bus.st_ready, bus.fill_req_ready); end
    tick();
    bus.fill_req_valid = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b1 || bus.st_ready !== 1'b0 || bus.wr_en !== 4'b0000) begin failures++; $display("FAIL arb_fill got busy=%b st_ready=%b wr_en=%b exp 1 0 0000", bus.busy, bus.st_ready, bus.wr_en); end
    for (int i = 0; i < 8; i++) begin
      bus.mem_valid = 1'b1;
      bus.mem_data  = 32'h50 + 32'(i);
      tick();
      checks++; if (bus.wr_en !== 4'b1000 || bus.wr_data !== 32'h50 + 32'(i) || bus.st_ready !== 1'b0) begin failures++; $display("FAIL arb_beat[%0d] got %b/%h st_ready=%b exp 1000/%h 0", i, bus.wr_en, bus.wr_data, bus.st_ready, 32'h50 + 32'(i)); end
    end
    bus.mem_valid = 1'b0;
    tick();
    #1;
    checks++; if (bus.st_ready !== 1'b1 || bus.wr_en !== 4'b0000) begin failures++; $display("FAIL arb_idle got st_ready=%b wr_en=%b exp 1 0000", bus.st_ready, bus.wr_en); end
    tick();
    bus.st_valid = 1'b0;
    checks++; if (bus.wr_en !== 4'b0001 || bus.wr_data !== 32'hDEADBEEF || bus.wr_offset !== 3'd2) begin failures++; $display("FAIL arb_store got %b/%0d/%h exp 0001/2/deadbeef", bus.wr_en, bus.wr_offset, bus.wr_data); end
    tick();
  endtask

  task automatic test_bad_way();
    bus.fill_req_valid = 1'b1; bus.fill_way = 4'b0110; bus.fill_index = 6'd1;
    #1;
    checks++; if (bus.fill_req_ready !== 1'b1) begin failures++; $display("FAIL bw_ready got %b exp 1", bus.fill_req_ready); end
    tick();
    bus.fill_req_valid = 1'b0;
    checks++; if (bus.err_way !== 1'b1 || bus.wr_en !== 4'b0000) begin failures++; $display("FAIL bw_err got err=%b wr_en=%b exp 1 0000", bus.err_way, bus.wr_en); end
    checks++; if (bus.busy !== 1'b0 || bus.mem_ready !== 1'b0 || bus.fill_req_ready !== 1'b1) begin failures++; $display("FAIL bw_idle got busy=%b mem_ready=%b ready=%b exp 0 0 1", bus.busy, bus.mem_ready, bus.fill_req_ready); end
    tick();
    checks++; if (bus.err_way !== 1'b0) begin failures++; $display("FAIL bw_pulse got %b exp 0", bus.err_way); end
    bus.st_valid = 1'b1; bus.st_way = 4'b0011; bus.st_data = 32'h12345678;
    tick();
    bus.st_valid = 1'b0;
    checks++; if (bus.err_way !== 1'b1 || bus.wr_en !== 4'b0000 || bus.wr_data !== 32'hDEADBEEF) begin failures++; $display("FAIL bw_store got err=%b wr_en=%b data=%h exp 1 0000 deadbeef", bus.err_way, bus.wr_en, bus.wr_data); end
    tick();
    checks++; if (bus.err_way !== 1'b0) begin failures++; $display("FAIL bw_store_pulse got %b exp 0", bus.err_way); end
  endtask

  task automatic test_reset_mid_fill();
    bus.fill_req_valid = 1'b1; bus.fill_way = 4'b1000; bus.fill_index = 6'd7;
    tick();
    bus.fill_req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.mem_valid = 1'b1;
      bus.mem_data  = 32'h70 + 32'(i);
      tick();
    end
    checks++; if (bus.wr_en !== 4'b1000 || bus.wr_data !== 32'h72) begin failures++; $display("FAIL rm_pre got %b/%h exp 1000/72", bus.wr_en, bus.wr_data); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (bus.wr_en !== 4'b0000 || bus.busy !== 1'b0 || bus.mem_ready !== 1'b0) begin failures++; $display("FAIL rm_async got wr_en=%b busy=%b mem_ready=%b exp 0000 0 0", bus.wr_en, bus.busy, bus.mem_ready); end
    checks++; if (bus.wr_offset !== 3'd0 || bus.wr_data !== 32'h0) begin failures++; $display("FAIL rm_clear got off=%0d data=%h exp 0 0", bus.wr_offset, bus.wr_data); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++; if (bus.wr_en !== 4'b0000 || bus.mem_ready !== 1'b0 || bus.fill_req_ready !== 1'b1) begin failures++; $display("FAIL rm_after got wr_en=%b mem_ready=%b ready=%b exp 0000 0 1", bus.wr_en, bus.mem_ready, bus.fill_req_ready); end
    tick();
    checks++; if (bus.wr_en !== 4'b0000 || bus.busy !== 1'b0) begin failures++; $display("FAIL rm_quiet got wr_en=%b busy=%b exp 0000 0", bus.wr_en, bus.busy); end
    bus.mem_valid = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_fill_basic();
    test_fill_stall();
    test_store();
    test_back_to_back();
    test_bad_way();
    test_reset_mid_fill();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
